// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - sequential DES subkey generator, K1..K16 or K16..K1 order
// One subkey per accepted advance; direction is latched at start.
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key_in,
  input  logic        advance,
  output logic [1:48] key_out,
  output logic        key_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [1:0]  r_state;
  logic        r_dec;
  logic [3:0]  r_step;
  logic [3:0]  r_round;
  logic [1:28] r_c;
  logic [1:28] r_d;
  logic [1:48] r_key;
  logic        r_valid;
  logic        r_done;

  logic [1:56] w_pc1;
  logic [1:28] w_c_nxt;
  logic [1:28] w_d_nxt;
  logic [1:56] w_cd_nxt;
  logic [1:48] w_pc2;
  logic        w_load;
  logic        w_adv;
  logic        w_last;
  logic        w_one;

  genvar g;
  for (g = 0; g < 56; g++) begin : g_pc1
    assign w_pc1[g+1] = key_in[PC1_TAB[g]];
  end

  assign w_cd_nxt = {w_c_nxt, w_d_nxt};

  for (g = 0; g < 48; g++) begin : g_pc2
    assign w_pc2[g+1] = w_cd_nxt[PC2_TAB[g]];
  end

  // Rounds 1, 2, 9 and 16 rotate by one bit; all others by two.
  function automatic logic one_shift(input logic [3:0] idx);
    return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
  endfunction

  assign w_load = (r_state == S_IDLE) && start;
  assign w_last = (r_step == 4'd15);
  assign w_adv  = (r_state == S_RUN) && advance && !w_last;

  always_comb begin
    w_one   = 1'b0;
    w_c_nxt = r_c;
    w_d_nxt = r_d;
    if (w_load) begin
      if (decrypt) begin
        w_c_nxt = w_pc1[1:28];
        w_d_nxt = w_pc1[29:56];
      end else begin
        w_c_nxt = {w_pc1[2:28], w_pc1[1]};
        w_d_nxt = {w_pc1[30:56], w_pc1[29]};
      end
    end else if (w_adv) begin
      if (r_dec) begin
        // Undo the rotation that produced the current round.
        w_one   = one_shift(r_round);
        w_c_nxt = w_one ? {r_c[28], r_c[1:27]} : {r_c[27:28], r_c[1:26]};
        w_d_nxt = w_one ? {r_d[28], r_d[1:27]} : {r_d[27:28], r_d[1:26]};
      end else begin
        w_one   = one_shift(r_round + 4'd1);
        w_c_nxt = w_one ? {r_c[2:28], r_c[1]} : {r_c[3:28], r_c[1:2]};
        w_d_nxt = w_one ? {r_d[2:28], r_d[1]} : {r_d[3:28], r_d[1:2]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dec   <= 1'b0;
      r_step  <= 4'd0;
      r_round <= 4'd0;
      r_c     <= '0;
      r_d     <= '0;
      r_key   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_dec   <= decrypt;
            r_step  <= 4'd0;
            r_round <= decrypt ? 4'd15 : 4'd0;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_key   <= w_pc2;
            r_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (advance) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_step  <= r_step + 4'd1;
              r_round <= r_dec ? (r_round - 4'd1) : (r_round + 4'd1);
              r_c     <= w_c_nxt;
              r_d     <= w_d_nxt;
              r_key   <= w_pc2;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_out   = r_key;
  assign key_valid = r_valid;
  assign round_idx = r_round;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - self-checking bench for des_key_sched
// Reference subkeys come from a from-scratch software key schedule.
module tb_des_key_sched;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KB = 64'h123456789ABCDEF0;
  localparam logic [63:0] KC = 64'h0E329232EA6D0D73;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic        advance;
  logic [47:0] key_out;
  logic        key_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  des_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .decrypt   (decrypt),
    .key_in    (key_in),
    .advance   (advance),
    .key_out   (key_out),
    .key_valid (key_valid),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          ph;    // 0 idle, 1 run, 2 done
  int          pos;   // subkeys already consumed in this run
  bit          mdec;
  logic [47:0] mk [16];
  logic [47:0] mlast;

  logic [47:0] seq_rec [16];
  logic [3:0]  rr_rec  [16];
  logic [47:0] seq_enc [16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Subkey of round r computed directly: PC-1, cumulative rotation, PC-2.
  function automatic logic [47:0] sw_subkey(input logic [63:0] k, input int r);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] o;
    int tot;
    tot = 0;
    for (int i = 1; i <= r; i++) tot += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-PC1[i]];
      d[27-i] = k[64-PC1[28+i]];
    end
    c  = (c << tot) | (c >> (28 - tot));
    d  = (d << tot) | (d >> (28 - tot));
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
    return o;
  endfunction

  function automatic int ridx();
    return mdec ? 15 - pos : pos;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      ph = 0; pos = 0; mlast = '0;
    end else begin
      case (ph)
        0: if (start) begin
          ph = 1; pos = 0; mdec = decrypt;
          for (int r = 0; r < 16; r++) mk[r] = sw_subkey(key_in, r + 1);
        end
        1: if (advance) begin
          if (pos == 15) ph = 2;
          else pos++;
        end
        default: ph = 0;
      endcase
      if (ph == 1) mlast = mk[ridx()];
    end
  endtask

  task automatic compare();
    check("key_valid", 64'(key_valid), 64'(ph == 1));
    check("busy", 64'(busy), 64'(ph != 0));
    check("done", 64'(done), 64'(ph == 2));
    check("key_out", 64'(key_out), 64'(mlast));
    if (ph == 1) check("round_idx", 64'(round_idx), 64'(ridx()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_start(input logic [63:0] k, input bit dec, input bit adv_too);
    key_in = k; decrypt = dec; start = 1'b1; advance = adv_too;
    tick();
    start = 1'b0; advance = 1'b0;
    key_in = {$urandom, $urandom}; decrypt = ~dec;
  endtask

  task automatic finish_run(input int maxgap, input int inject_at);
    int gap;
    for (int s = 0; s < 16; s++) begin
      if (s == inject_at) begin
        key_in = KC; decrypt = ~decrypt; start = 1'b1;
        tick();
        start = 1'b0;
      end
      gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      repeat (gap) tick();
      seq_rec[s] = key_out;
      rr_rec[s]  = round_idx;
      advance = 1'b1;
      tick();
      advance = 1'b0;
    end
    check("done_pulse", 64'(done), 64'd1);
    tick();
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [63:0] k, input bit dec, input int maxgap, input bit adv_too);
    do_start(k, dec, adv_too);
    finish_run(maxgap, -1);
  endtask

  initial begin
    logic [63:0] rk;
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key_in = '0; advance = 1'b0;
    ph = 0; pos = 0; mdec = 1'b0; mlast = '0;
    #1;
    check("rst_key_out", 64'(key_out), 64'd0);
    check("rst_valid", 64'(key_valid), 64'd0);
    check("rst_round", 64'(round_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Known-answer pins on the software schedule itself
    check("model_k1", 64'(sw_subkey(KA, 1)), 64'h1B02EFFC7072);
    check("model_k2", 64'(sw_subkey(KA, 2)), 64'h79AED9DBC9E5);
    check("model_k16", 64'(sw_subkey(KA, 16)), 64'hCB3D8B0E17F5);

    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Encrypt, advance every cycle; advance also high with start
    run(KA, 1'b0, 0, 1'b1);
    check("enc_k1", 64'(seq_rec[0]), 64'h1B02EFFC7072);
    check("enc_k2", 64'(seq_rec[1]), 64'h79AED9DBC9E5);
    check("enc_k16", 64'(seq_rec[15]), 64'hCB3D8B0E17F5);
    check("enc_r0", 64'(rr_rec[0]), 64'd0);
    check("enc_r15", 64'(rr_rec[15]), 64'd15);
    for (int s = 0; s < 16; s++) seq_enc[s] = seq_rec[s];

    // Decrypt, same key
    run(KA, 1'b1, 0, 1'b0);
    check("dec_first", 64'(seq_rec[0]), 64'hCB3D8B0E17F5);
    check("dec_first_r", 64'(rr_rec[0]), 64'd15);
    check("dec_second", 64'(seq_rec[1]), 64'(seq_enc[14]));
    check("dec_last", 64'(seq_rec[15]), 64'h1B02EFFC7072);
    check("dec_last_r", 64'(rr_rec[15]), 64'd0);
    for (int s = 0; s < 16; s++) check("dec_reverse", 64'(seq_rec[s]), 64'(seq_enc[15-s]));

    // Parity bits do not matter
    run(KB, 1'b0, 2, 1'b0);
    for (int s = 0; s < 16; s++) check("parity", 64'(seq_rec[s]), 64'(seq_enc[s]));

    // start mid-run ignored, then accepted in first IDLE cycle after done
    do_start(KA, 1'b0, 1'b0);
    finish_run(0, 7);
    for (int s = 0; s < 16; s++) check("start_ignored", 64'(seq_rec[s]), 64'(seq_enc[s]));
    do_start(KC, 1'b0, 1'b0);
    check("new_key_k1", 64'(key_out), 64'(sw_subkey(KC, 1)));
    finish_run(1, -1);

    // Asynchronous reset mid-run at round 9
    do_start(KA, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) begin
      advance = 1'b1; tick(); advance = 1'b0;
    end
    check("pre_rst_round", 64'(round_idx), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_key_out", 64'(key_out), 64'd0);
    check("arst_valid", 64'(key_valid), 64'd0);
    check("arst_round", 64'(round_idx), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    run(KA, 1'b0, 0, 1'b0);
    check("post_rst_k1", 64'(seq_rec[0]), 64'h1B02EFFC7072);

    // Random keys with random advance gaps in both directions
    for (int i = 0; i < 50; i++) begin
      rk = {$urandom, $urandom};
      run(rk, 1'b0, 5, 1'b0);
      for (int s = 0; s < 16; s++) seq_enc[s] = seq_rec[s];
      run(rk, 1'b1, 5, 1'b0);
      for (int s = 0; s < 16; s++) check("rand_reverse", 64'(seq_rec[s]), 64'(seq_enc[15-s]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
